// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM encoding,
// port identifiers and lock-timer sizing.
package dmem_arb_pkg;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_LOAD = 1'b1;

    localparam int MAX_LOCK_DEF = 16;
    // MAX_LOCK is limited to 1..255, so eight bits always hold the count.
    localparam int LOCK_CNT_W   = 8;

endpackage

// File: rtl/dmem_arb_lock_timer.sv
// Counts consecutive locked cycles for port 1 and flags the cycle in which
// the lock has to be taken away.
module dmem_arb_lock_timer
    import dmem_arb_pkg::*;
#(
    parameter int MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic force_rel_o
);

    logic [LOCK_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = LOCK_CNT_W'(1);
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + LOCK_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_rel_o = (cnt_q == LOCK_CNT_W'(MAX_LOCK));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the synchronous-read data memory: core (port 0)
// and loader/debug (port 1). Optional perf counters under DMEM_ARB_PERF_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              lock1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lock_active
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_gnt0,
    output logic [31:0]       perf_gnt1,
    output logic [31:0]       perf_conflict
`endif
);

    arb_state_e state_q, state_d;
    logic       last_gnt_q, last_gnt_d;
    logic       prio_q, prio_d;
    logic       rd_vld_q, rd_vld_d;
    logic       rd_own_q, rd_own_d;
    logic       g0, g1;
    logic       tmr_load, tmr_inc, tmr_clr, force_rel;
    logic       locked;

    assign locked = (state_q == ARB_LOCKED);

    // Grants are suppressed while reset is held so every output sits at its
    // reset value even though requests are combinational inputs.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (rst) begin
            if (locked) begin
                g1 = req1;
            end else if (prio_q && req0) begin
                g0 = 1'b1;
            end else if (req0 && req1) begin
                if (last_gnt_q == PORT_CORE) g1 = 1'b1;
                else                         g0 = 1'b1;
            end else begin
                g0 = req0;
                g1 = req1;
            end
        end
    end

    assign gnt0 = g0;
    assign gnt1 = g1;

    always_comb begin
        mem_en    = g0 | g1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (g0) begin
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (g1) begin
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    always_comb begin
        state_d  = state_q;
        prio_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_inc  = 1'b0;
        tmr_clr  = 1'b0;
        if (state_q == ARB_OPEN) begin
            // No relock during the cycle that follows a forced release.
            if (g1 && lock1 && !prio_q) begin
                state_d  = ARB_LOCKED;
                tmr_load = 1'b1;
            end
        end else begin
            if (!lock1) begin
                state_d = ARB_OPEN;
                tmr_clr = 1'b1;
            end else if (force_rel) begin
                state_d = ARB_OPEN;
                tmr_clr = 1'b1;
                prio_d  = 1'b1;
            end else begin
                tmr_inc = 1'b1;
            end
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (g0)      last_gnt_d = PORT_CORE;
        else if (g1) last_gnt_d = PORT_LOAD;
        rd_vld_d = mem_en & ~mem_we;
        rd_own_d = g1 ? PORT_LOAD : PORT_CORE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB_OPEN;
            last_gnt_q <= PORT_LOAD;
            prio_q     <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_own_q   <= PORT_CORE;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            prio_q     <= prio_d;
            rd_vld_q   <= rd_vld_d;
            rd_own_q   <= rd_own_d;
        end
    end

    dmem_arb_lock_timer #(
        .MAX_LOCK (MAX_LOCK)
    ) u_lock_timer (
        .clk         (clk),
        .rst         (rst),
        .load_i      (tmr_load),
        .inc_i       (tmr_inc),
        .clr_i       (tmr_clr),
        .force_rel_o (force_rel)
    );

    assign rvalid0     = rd_vld_q & (rd_own_q == PORT_CORE);
    assign rvalid1     = rd_vld_q & (rd_own_q == PORT_LOAD);
    assign rdata0      = rvalid0 ? mem_rdata : '0;
    assign rdata1      = rvalid1 ? mem_rdata : '0;
    assign lock_active = locked;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] pg0_q, pg1_q, pcf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pg0_q <= '0;
            pg1_q <= '0;
            pcf_q <= '0;
        end else begin
            if (g0 && (pg0_q != '1)) pg0_q <= pg0_q + 32'd1;
            if (g1 && (pg1_q != '1)) pg1_q <= pg1_q + 32'd1;
            // With both requesting, one side is always denied (arbitration or lock).
            if (req0 && req1 && (pcf_q != '1)) pcf_q <= pcf_q + 32'd1;
        end
    end

    assign perf_gnt0     = pg0_q;
    assign perf_gnt1     = pg1_q;
    assign perf_conflict = pcf_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a per-cycle vector table plus hand-written
// lock-timeout and mid-read reset sequences.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0, lock1 = 0;
    logic [31:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0, mem_rdata = 0;

    logic        gnt0, rvalid0, gnt1, rvalid1, mem_en, mem_we, lock_active;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
    logic        gnt0_b, rvalid0_b, gnt1_b, rvalid1_b, mem_en_b, mem_we_b, lock_active_b;
    logic [31:0] rdata0_b, rdata1_b, mem_addr_b, mem_wdata_b;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_gnt0, perf_gnt1, perf_conflict;
    logic [31:0] perf_gnt0_b, perf_gnt1_b, perf_conflict_b;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .lock1(lock1), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .lock_active(lock_active)
`ifdef DMEM_ARB_PERF_EN
        , .perf_gnt0(perf_gnt0), .perf_gnt1(perf_gnt1), .perf_conflict(perf_conflict)
`endif
    );

    dmem_arbiter #(.MAX_LOCK(4)) dut4 (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0_b), .rvalid0(rvalid0_b), .rdata0(rdata0_b),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1_b), .rvalid1(rvalid1_b), .rdata1(rdata1_b),
        .lock1(lock1), .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata), .lock_active(lock_active_b)
`ifdef DMEM_ARB_PERF_EN
        , .perf_gnt0(perf_gnt0_b), .perf_gnt1(perf_gnt1_b), .perf_conflict(perf_conflict_b)
`endif
    );

    typedef struct {
        logic [31:0] rst, r0, w0, a0, d0, r1, w1, a1, d1, lk, mrd;
        logic [31:0] g0, g1, v0, v1, rd0, rd1, en, we, ma, md, la;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        lock1 = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic apply(input int i);
        @(negedge clk);
        rst = tbl[i].rst[0];
        req0 = tbl[i].r0[0]; we0 = tbl[i].w0[0]; addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
        req1 = tbl[i].r1[0]; we1 = tbl[i].w1[0]; addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
        lock1 = tbl[i].lk[0]; mem_rdata = tbl[i].mrd;
        #1;
        chk($sformatf("row%0d.gnt0", i), 32'(gnt0), tbl[i].g0);
        chk($sformatf("row%0d.gnt1", i), 32'(gnt1), tbl[i].g1);
        chk($sformatf("row%0d.rvalid0", i), 32'(rvalid0), tbl[i].v0);
        chk($sformatf("row%0d.rvalid1", i), 32'(rvalid1), tbl[i].v1);
        chk($sformatf("row%0d.rdata0", i), rdata0, tbl[i].rd0);
        chk($sformatf("row%0d.rdata1", i), rdata1, tbl[i].rd1);
        chk($sformatf("row%0d.mem_en", i), 32'(mem_en), tbl[i].en);
        chk($sformatf("row%0d.mem_we", i), 32'(mem_we), tbl[i].we);
        chk($sformatf("row%0d.mem_addr", i), mem_addr, tbl[i].ma);
        chk($sformatf("row%0d.mem_wdata", i), mem_wdata, tbl[i].md);
        chk($sformatf("row%0d.lock_active", i), 32'(lock_active), tbl[i].la);
    endtask

    initial begin
        //          rst r0 w0 a0     d0 r1 w1 a1     d1 lk mrd           g0 g1 v0 v1 rd0          rd1    en we ma     md la
        tbl[0]  = '{1, 0, 0, 0,     0, 0, 0, 0,     0, 0, 0,            0, 0, 0, 0, 0,           0,     0, 0, 0,     0, 0};
        tbl[1]  = '{1, 1, 0, 'h10,  0, 0, 0, 0,     0, 0, 0,            1, 0, 0, 0, 0,           0,     1, 0, 'h10,  0, 0};
        tbl[2]  = '{1, 0, 0, 0,     0, 0, 0, 0,     0, 0, 'hDEADBEEF,   0, 0, 1, 0, 'hDEADBEEF,  0,     0, 0, 0,     0, 0};
        tbl[3]  = '{0, 1, 0, 'h20,  0, 1, 0, 'h30,  0, 0, 'h1234,       0, 0, 0, 0, 0,           0,     0, 0, 0,     0, 0};
        tbl[4]  = '{1, 1, 0, 'h20,  0, 1, 0, 'h30,  0, 0, 0,            1, 0, 0, 0, 0,           0,     1, 0, 'h20,  0, 0};
        tbl[5]  = '{1, 1, 0, 'h20,  0, 1, 0, 'h30,  0, 0, 'hA0,         0, 1, 1, 0, 'hA0,        0,     1, 0, 'h30,  0, 0};
        tbl[6]  = '{1, 1, 0, 'h20,  0, 1, 0, 'h30,  0, 0, 'hA1,         1, 0, 0, 1, 0,           'hA1,  1, 0, 'h20,  0, 0};
        tbl[7]  = '{1, 1, 0, 'h20,  0, 1, 0, 'h30,  0, 0, 'hA2,         0, 1, 1, 0, 'hA2,        0,     1, 0, 'h30,  0, 0};
        tbl[8]  = '{1, 0, 0, 0,     0, 0, 0, 0,     0, 0, 'hA3,         0, 0, 0, 1, 0,           'hA3,  0, 0, 0,     0, 0};
        tbl[9]  = '{1, 0, 0, 0,     0, 1, 1, 'h100, 1, 1, 0,            0, 1, 0, 0, 0,           0,     1, 1, 'h100, 1, 0};
        tbl[10] = '{1, 1, 0, 'h40,  0, 1, 1, 'h101, 2, 1, 0,            0, 1, 0, 0, 0,           0,     1, 1, 'h101, 2, 1};
        tbl[11] = '{1, 1, 0, 'h40,  0, 1, 1, 'h102, 3, 1, 0,            0, 1, 0, 0, 0,           0,     1, 1, 'h102, 3, 1};
        tbl[12] = '{1, 1, 0, 'h40,  0, 1, 1, 'h103, 4, 1, 0,            0, 1, 0, 0, 0,           0,     1, 1, 'h103, 4, 1};
        tbl[13] = '{1, 1, 0, 'h40,  0, 1, 1, 'h104, 5, 0, 0,            0, 1, 0, 0, 0,           0,     1, 1, 'h104, 5, 1};
        tbl[14] = '{1, 1, 0, 'h40,  0, 0, 0, 0,     0, 0, 0,            1, 0, 0, 0, 0,           0,     1, 0, 'h40,  0, 0};
        tbl[15] = '{1, 0, 0, 0,     0, 0, 0, 0,     0, 0, 'hB0,         0, 0, 1, 0, 'hB0,        0,     0, 0, 0,     0, 0};

        // Reset state with requests pending: everything must stay quiet.
        req0 = 1; req1 = 1; mem_rdata = 32'h5A5A5A5A;
        #2;
        chk("rst.gnt0", 32'(gnt0), 0);
        chk("rst.gnt1", 32'(gnt1), 0);
        chk("rst.mem_en", 32'(mem_en), 0);
        chk("rst.rdata0", rdata0, 0);
        chk("rst.lock_active", 32'(lock_active), 0);
        do_reset();

        for (int i = 0; i <= 8; i++) apply(i);
`ifdef DMEM_ARB_PERF_EN
        chk("perf.gnt0", perf_gnt0, 2);
        chk("perf.gnt1", perf_gnt1, 2);
        chk("perf.conflict", perf_conflict, 4);
`endif
        for (int i = 9; i < NV; i++) apply(i);

        // Lock timeout on the MAX_LOCK=4 instance.
        do_reset();
        @(negedge clk);
        drive_idle();
        req1 = 1; we1 = 1; addr1 = 32'h200; wdata1 = 32'h7; lock1 = 1;
        #1;
        chk("to.entry.gnt1", 32'(gnt1_b), 1);
        chk("to.entry.lock", 32'(lock_active_b), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req0 = 1; addr0 = 32'h50;
            #1;
            chk($sformatf("to.locked%0d.lock", k), 32'(lock_active_b), 1);
            chk($sformatf("to.locked%0d.gnt0", k), 32'(gnt0_b), 0);
            chk($sformatf("to.locked%0d.gnt1", k), 32'(gnt1_b), 1);
        end
        @(negedge clk);
        #1;
        chk("to.rel.lock", 32'(lock_active_b), 0);
        chk("to.rel.gnt0", 32'(gnt0_b), 1);
        chk("to.rel.gnt1", 32'(gnt1_b), 0);
        @(negedge clk);
        #1;
        chk("to.regain.gnt0", 32'(gnt0_b), 0);
        chk("to.regain.gnt1", 32'(gnt1_b), 1);
        @(negedge clk);
        #1;
        chk("to.relocked.lock", 32'(lock_active_b), 1);
        chk("to.relocked.gnt0", 32'(gnt0_b), 0);

        // Reset lands while a port-1 read is outstanding.
        do_reset();
        @(negedge clk);
        drive_idle();
        req0 = 1; addr0 = 32'h60;
        #1;
        chk("mr.pre.gnt0", 32'(gnt0), 1);
        @(negedge clk);
        req0 = 0; req1 = 1; addr1 = 32'h70; mem_rdata = 32'h5555;
        #1;
        chk("mr.rd.gnt1", 32'(gnt1), 1);
        rst = 1'b0;
        #1;
        chk("mr.rst.gnt1", 32'(gnt1), 0);
        chk("mr.rst.rvalid0", 32'(rvalid0), 0);
        chk("mr.rst.rvalid1", 32'(rvalid1), 0);
        chk("mr.rst.rdata0", rdata0, 0);
        chk("mr.rst.rdata1", rdata1, 0);
        chk("mr.rst.mem_en", 32'(mem_en), 0);
        chk("mr.rst.mem_we", 32'(mem_we), 0);
        chk("mr.rst.mem_addr", mem_addr, 0);
        chk("mr.rst.mem_wdata", mem_wdata, 0);
        chk("mr.rst.lock", 32'(lock_active), 0);
        @(negedge clk);
        rst = 1'b1; req1 = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("mr.post%0d.rvalid1", k), 32'(rvalid1), 0);
            @(negedge clk);
        end
        req0 = 1; req1 = 1; addr0 = 32'h80; addr1 = 32'h90;
        #1;
        chk("mr.conflict.gnt0", 32'(gnt0), 1);
        chk("mr.conflict.gnt1", 32'(gnt1), 0);
        @(negedge clk);
        drive_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
